// File: rtl/wb_daq_channel_arbiter_pkg.sv
// Shared definitions for the DAQ channel arbiter.
//   - state_t          : arbiter FSM state encoding (3 bits)
//   - TXN_PER_SAMPLE_DEFAULT / TIMEOUT_DEFAULT : default parameter values
//   - CTRL_ERR_CLR_BIT : control_reg bit that clears the sticky timeout flag
//   - MASTER_SEL_ALL   : byte-select value driven to the bus master
//   - wrap_add()       : (base + off) mod n for base, off < n
package wb_daq_channel_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int TXN_PER_SAMPLE_DEFAULT = 5;
  localparam int TIMEOUT_DEFAULT        = 1024;
  localparam int CTRL_ERR_CLR_BIT       = 31;
  localparam logic [3:0] MASTER_SEL_ALL = 4'hF;

  // Both operands are already below n, so one conditional subtract
  // replaces a general modulo.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/wb_daq_channel_arbiter_rr_picker.sv
// Combinational round-robin priority select.
//   req        : per-channel eligible requests
//   rr_ptr     : index that has highest priority this cycle
//   winner     : one-hot of the first requester at or after rr_ptr (wrapping)
//   winner_idx : binary index of that requester
//   any_req    : at least one request is present
module wb_daq_rr_picker
  import wb_daq_channel_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PTR_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]        rr_ptr,
  output logic [NUM_CHANNELS-1:0] winner,
  output logic [PTR_W-1:0]        winner_idx,
  output logic                    any_req
);

  logic [PTR_W-1:0] probe_idx;

  // Scan from the farthest offset back to rr_ptr so the nearest requester
  // is the last one written and therefore the one that sticks.
  always_comb begin
    winner_idx = '0;
    any_req    = 1'b0;
    probe_idx  = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      probe_idx = PTR_W'(wrap_add(int'(rr_ptr), k, NUM_CHANNELS));
      if (req[probe_idx]) begin
        winner_idx = probe_idx;
        any_req    = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_onehot
    assign winner[gi] = any_req && (winner_idx == PTR_W'(gi));
  end

endmodule

// File: rtl/wb_daq_channel_arbiter.sv
// Round-robin arbiter sharing one DAQ Wishbone bus master among channels.
// One sample is accepted per grant, handed to the bus master with the
// channel's descriptor base as a one-cycle start, and completion is tracked
// by counting falling edges of the master's cyc line.
//   wb_clk, wb_rst   : clock, synchronous active-high reset
//   control_reg      : [NUM_CHANNELS-1:0] channel enables, [31] error clear
//   base_addresses   : per-channel descriptor base, channel i at [i*aw +: aw]
//   ch_valid/ch_data : per-channel sample sources; ch_ready is one-hot accept
//   master_*         : start pulse, address, data, select, write to bus master
//   master_cyc       : bus master wb_cyc_o
//   grant            : one-hot granted channel, held from ISSUE through DONE
//   busy             : arbiter not idle
//   sample_done      : one-cycle pulse on successful completion
//   timeout_err      : sticky flag, set when the bus master stalls too long
module wb_daq_channel_arbiter
  import wb_daq_channel_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int TXN_PER_SAMPLE = TXN_PER_SAMPLE_DEFAULT,
  parameter int TIMEOUT        = TIMEOUT_DEFAULT
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic [dw-1:0]              control_reg,
  input  logic [NUM_CHANNELS*aw-1:0] base_addresses,
  input  logic [NUM_CHANNELS-1:0]    ch_valid,
  input  logic [NUM_CHANNELS*dw-1:0] ch_data,
  output logic [NUM_CHANNELS-1:0]    ch_ready,
  output logic                       master_start,
  output logic [aw-1:0]              master_address,
  output logic [dw-1:0]              master_data_wr,
  output logic [3:0]                 master_selection,
  output logic                       master_write,
  input  logic                       master_cyc,
  output logic [NUM_CHANNELS-1:0]    grant,
  output logic                       busy,
  output logic                       sample_done,
  output logic                       timeout_err
);

  localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TXN_W = $clog2(TXN_PER_SAMPLE + 1);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]        grant_idx_reg, grant_idx_next;
  logic [NUM_CHANNELS-1:0] grant_reg, grant_next;
  logic [aw-1:0]           addr_reg, addr_next;
  logic [dw-1:0]           data_reg, data_next;
  logic [TXN_W-1:0]        txn_cnt_reg, txn_cnt_next;
  logic [TMR_W-1:0]        timer_reg, timer_next;
  logic                    low_seen_reg, low_seen_next;
  logic                    err_reg, err_next;
  logic                    cyc_q_reg;

  logic [NUM_CHANNELS-1:0] req, winner;
  logic [PTR_W-1:0]        winner_idx;
  logic                    any_req;
  logic                    cyc_fall, txn_last, timer_last, err_set;

  logic [dw-1:0] data_lane [NUM_CHANNELS];
  logic [aw-1:0] addr_lane [NUM_CHANNELS];

  // Only the enable bits and the error-clear bit carry meaning.
  logic unused_ctrl;
  assign unused_ctrl = ^control_reg;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
    assign req[gi]       = ch_valid[gi] & control_reg[gi];
    assign data_lane[gi] = ch_data[gi*dw +: dw];
    assign addr_lane[gi] = base_addresses[gi*aw +: aw];
  end

  wb_daq_rr_picker #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .PTR_W       (PTR_W)
  ) u_picker (
    .req       (req),
    .rr_ptr    (rr_ptr_reg),
    .winner    (winner),
    .winner_idx(winner_idx),
    .any_req   (any_req)
  );

  assign cyc_fall   = cyc_q_reg & ~master_cyc;
  assign txn_last   = (txn_cnt_reg == TXN_W'(TXN_PER_SAMPLE - 1));
  assign timer_last = (timer_reg == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      grant_reg     <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      txn_cnt_reg   <= '0;
      timer_reg     <= '0;
      low_seen_reg  <= 1'b0;
      err_reg       <= 1'b0;
      cyc_q_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_idx_reg <= grant_idx_next;
      grant_reg     <= grant_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      txn_cnt_reg   <= txn_cnt_next;
      timer_reg     <= timer_next;
      low_seen_reg  <= low_seen_next;
      err_reg       <= err_next;
      cyc_q_reg     <= master_cyc;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_idx_next = grant_idx_reg;
    grant_next     = grant_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    txn_cnt_next   = txn_cnt_reg;
    timer_next     = timer_reg;
    low_seen_next  = low_seen_reg;
    err_set        = 1'b0;

    ch_ready     = '0;
    master_start = (state_reg == ST_ISSUE);
    sample_done  = (state_reg == ST_DONE);
    busy         = (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        // ch_ready is the handshake: whenever a winner exists it is accepted.
        if (!wb_rst) ch_ready = winner;
        if (any_req) begin
          addr_next      = addr_lane[winner_idx];
          data_next      = data_lane[winner_idx];
          grant_next     = winner;
          grant_idx_next = winner_idx;
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        txn_cnt_next = '0;
        timer_next   = '0;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        timer_next = timer_reg + 1'b1;
        if (cyc_fall) txn_cnt_next = txn_cnt_reg + 1'b1;
        // Completion is tested first so it wins over a timeout on the
        // final timer cycle.
        if (cyc_fall && txn_last) begin
          state_next = ST_DONE;
        end else if (timer_last) begin
          err_set       = 1'b1;
          low_seen_next = 1'b0;
          state_next    = ST_ERROR;
        end
      end
      ST_DONE: begin
        grant_next  = '0;
        rr_ptr_next = PTR_W'(wrap_add(int'(grant_idx_reg), 1, NUM_CHANNELS));
        state_next  = ST_IDLE;
      end
      ST_ERROR: begin
        // Release the bus only after the master has been idle for two
        // consecutive cycles, so a late cycle cannot overlap a new sample.
        if (master_cyc) begin
          low_seen_next = 1'b0;
        end else if (low_seen_reg) begin
          low_seen_next = 1'b0;
          grant_next    = '0;
          rr_ptr_next   = PTR_W'(wrap_add(int'(grant_idx_reg), 1, NUM_CHANNELS));
          state_next    = ST_IDLE;
        end else begin
          low_seen_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (err_set)                           err_next = 1'b1;
    else if (control_reg[CTRL_ERR_CLR_BIT]) err_next = 1'b0;
    else                                   err_next = err_reg;
  end

  assign grant            = grant_reg;
  assign master_address   = addr_reg;
  assign master_data_wr   = data_reg;
  assign master_selection = MASTER_SEL_ALL;
  assign master_write     = 1'b1;
  assign timeout_err      = err_reg;

endmodule

// File: tb/tb_wb_daq_channel_arbiter.sv
// Bench for wb_daq_channel_arbiter: directed scenarios plus randomized
// samples, each checked against a transaction-level timeline derived from
// the round-robin rule and the bus master's cyc pattern.
module tb_wb_daq_channel_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TXN = 5;
  localparam int TMO = 16;

  logic            wb_clk = 1'b0;
  logic            wb_rst;
  logic [DW-1:0]   control_reg;
  logic [N*AW-1:0] base_addresses;
  logic [N-1:0]    ch_valid;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    ch_ready;
  logic            master_start;
  logic [AW-1:0]   master_address;
  logic [DW-1:0]   master_data_wr;
  logic [3:0]      master_selection;
  logic            master_write;
  logic            master_cyc;
  logic [N-1:0]    grant;
  logic            busy;
  logic            sample_done;
  logic            timeout_err;

  wb_daq_channel_arbiter #(
    .NUM_CHANNELS  (N),
    .dw            (DW),
    .aw            (AW),
    .TXN_PER_SAMPLE(TXN),
    .TIMEOUT       (TMO)
  ) dut (
    .wb_clk          (wb_clk),
    .wb_rst          (wb_rst),
    .control_reg     (control_reg),
    .base_addresses  (base_addresses),
    .ch_valid        (ch_valid),
    .ch_data         (ch_data),
    .ch_ready        (ch_ready),
    .master_start    (master_start),
    .master_address  (master_address),
    .master_data_wr  (master_data_wr),
    .master_selection(master_selection),
    .master_write    (master_write),
    .master_cyc      (master_cyc),
    .grant           (grant),
    .busy            (busy),
    .sample_done     (sample_done),
    .timeout_err     (timeout_err)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;
  int rr_model = 0;
  int txn_no = 0;
  bit cyc_seq[$];  // cyc value per cycle: [0]=ISSUE, [j]=WAIT cycle j, then ERROR

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got 0x%0h expected 0x%0h", tag, txn_no, got, exp);
    end
  endtask

  function automatic bit cyc_at(input int j);
    if (j < cyc_seq.size()) return cyc_seq[j];
    return 1'b0;
  endfunction

  // First eligible channel at or after ptr, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = req >> ((ptr + k) % N);
      if (sh[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic scramble_lanes();
    ch_data        = {$urandom, $urandom, $urandom, $urandom};
    base_addresses = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic seq_pulses(input int lead_zeros);
    cyc_seq.delete();
    cyc_seq.push_back(1'b0);
    repeat (lead_zeros) cyc_seq.push_back(1'b0);
    repeat (TXN) begin
      cyc_seq.push_back(1'b1);
      cyc_seq.push_back(1'b0);
    end
  endtask

  task automatic seq_random();
    cyc_seq.delete();
    cyc_seq.push_back(1'b0);
    for (int t = 0; t < TXN; t++) begin
      if ($urandom_range(0, 3) == 0) cyc_seq.push_back(1'b0);
      repeat ($urandom_range(1, 2)) cyc_seq.push_back(1'b1);
      cyc_seq.push_back(1'b0);
    end
  endtask

  // Timeline relative to the handshake cycle (r=0): ISSUE at r=1, WAIT
  // cycle j at r=j+1. The 5th falling edge within the first TMO WAIT cycles
  // completes; otherwise the error flag shows from r=TMO+2 and the arbiter
  // idles once the bus was low for two consecutive ERROR cycles.
  task automatic plan_txn(output int done_r, output int err_r, output int end_r);
    int falls;
    falls = 0;
    done_r = 0;
    err_r = 0;
    end_r = 0;
    for (int j = 1; j <= TMO; j++) begin
      if (cyc_at(j - 1) && !cyc_at(j)) falls++;
      if (falls == TXN) begin
        done_r = j + 2;
        end_r = j + 3;
        return;
      end
    end
    err_r = TMO + 2;
    for (int e = 2; e < 200; e++) begin
      if (!cyc_at(TMO + e) && !cyc_at(TMO + e - 1)) begin
        end_r = TMO + 2 + e;
        return;
      end
    end
  endtask

  task automatic run_txn(input logic [N-1:0] en, input logic [N-1:0] val);
    int w, done_r, err_r, end_r;
    logic [N-1:0] oh;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    txn_no++;
    @(posedge wb_clk);
    #1;
    control_reg = 32'(en);
    ch_valid = val;
    master_cyc = 1'b0;
    #1;
    w = pick(en & val, rr_model);
    if (w < 0) begin
      check_eq("ready_none", 64'(ch_ready), 64'(0));
      @(posedge wb_clk);
      #1;
      ch_valid = '0;
      #1;
      check_eq("idle_stays", 64'(busy), 64'(0));
      $display("txn %0d: en=%b valid=%b no eligible request", txn_no, en, val);
      return;
    end
    oh = N'(1 << w);
    exp_addr = AW'(base_addresses >> (w * AW));
    exp_data = DW'(ch_data >> (w * DW));
    check_eq("ready_hs", 64'(ch_ready), 64'(oh));
    check_eq("busy_hs", 64'(busy), 64'(0));
    check_eq("sel_const", 64'(master_selection), 64'(4'hF));
    check_eq("we_const", 64'(master_write), 64'(1));
    plan_txn(done_r, err_r, end_r);
    for (int r = 1; r <= end_r; r++) begin
      @(posedge wb_clk);
      #1;
      master_cyc = cyc_at(r - 1);
      ch_valid = (r == end_r) ? '0 : N'($urandom);
      control_reg = 32'(N'($urandom));
      control_reg[31] = (err_r != 0) && (r == TMO + 1);
      scramble_lanes();
      #1;
      check_eq("start", 64'(master_start), 64'(r == 1));
      check_eq("done", 64'(sample_done), 64'(r == done_r));
      check_eq("busy", 64'(busy), 64'(r < end_r));
      check_eq("grant", 64'(grant), 64'((r < end_r) ? oh : '0));
      check_eq("ready_busy", 64'(ch_ready), 64'(0));
      check_eq("addr", 64'(master_address), 64'(exp_addr));
      check_eq("data", 64'(master_data_wr), 64'(exp_data));
      check_eq("tmo_err", 64'(timeout_err), 64'((err_r != 0) && (r >= err_r)));
    end
    rr_model = (w + 1) % N;
    $display("txn %0d: en=%b valid=%b ch=%0d addr=%h data=%h %s", txn_no, en, val, w,
             exp_addr, exp_data, (err_r != 0) ? "timeout" : "done");
    if (err_r != 0) begin
      @(posedge wb_clk);
      #1;
      control_reg = 32'h8000_0000;
      #1;
      check_eq("err_sticky", 64'(timeout_err), 64'(1));
      @(posedge wb_clk);
      #1;
      control_reg = '0;
      #1;
      check_eq("err_clear", 64'(timeout_err), 64'(0));
    end
  endtask

  task automatic pulse_reset();
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b1;
    ch_valid = '0;
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    rr_model = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wb_rst = 1'b1;
    control_reg = 32'hF;
    ch_valid = '1;
    master_cyc = 1'b0;
    scramble_lanes();
    @(posedge wb_clk);
    #1;
    check_eq("rst_ready", 64'(ch_ready), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_grant", 64'(grant), 64'(0));
    check_eq("rst_start", 64'(master_start), 64'(0));
    check_eq("rst_addr", 64'(master_address), 64'(0));
    check_eq("rst_data", 64'(master_data_wr), 64'(0));
    check_eq("rst_done", 64'(sample_done), 64'(0));
    check_eq("rst_err", 64'(timeout_err), 64'(0));
    $display("reset: outputs checked");
    wb_rst = 1'b0;
    ch_valid = '0;

    // Single channel with known data/base
    ch_data[31:0] = 32'hDEAD_BEEF;
    base_addresses[31:0] = 32'h0000_1000;
    seq_pulses(0);
    run_txn(4'b0001, 4'b0001);

    // Round robin from a fresh pointer: 0,1,2,3,0
    pulse_reset();
    repeat (5) begin
      scramble_lanes();
      seq_random_complete();
      run_txn(4'b1111, 4'b1111);
    end

    // Disabled channels 0 and 2
    repeat (4) begin
      scramble_lanes();
      seq_pulses(1);
      run_txn(4'b1010, 4'b1111);
    end

    // Timeout: bus never cycles
    scramble_lanes();
    cyc_seq.delete();
    cyc_seq.push_back(1'b0);
    run_txn(4'b0001, 4'b0001);

    // 5th fall on the final timer cycle completes; one cycle later times out
    scramble_lanes();
    seq_pulses(6);
    run_txn(4'b1111, 4'b1111);
    scramble_lanes();
    seq_pulses(7);
    run_txn(4'b1111, 4'b1111);

    // Reset mid-WAIT: complete channel 2 (pointer -> 3), then hold
    // channel 3 in flight for two transactions and reset.
    scramble_lanes();
    seq_pulses(0);
    run_txn(4'b0100, 4'b0100);
    txn_no++;
    @(posedge wb_clk);
    #1;
    control_reg = 32'h8;
    ch_valid = 4'b1000;
    master_cyc = 1'b0;
    #1;
    check_eq("mid_ready", 64'(ch_ready), 64'(4'b1000));
    for (int r = 1; r <= 5; r++) begin
      @(posedge wb_clk);
      #1;
      ch_valid = '0;
      master_cyc = (r == 2) || (r == 4);
      #1;
      check_eq("mid_grant", 64'(grant), 64'(4'b1000));
    end
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b1;
    ch_valid = '1;
    control_reg = 32'hF;
    master_cyc = 1'b1;
    #1;
    check_eq("mid_rst_ready", 64'(ch_ready), 64'(0));
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    ch_valid = '0;
    master_cyc = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'(0));
    check_eq("mid_rst_grant", 64'(grant), 64'(0));
    check_eq("mid_rst_addr", 64'(master_address), 64'(0));
    check_eq("mid_rst_data", 64'(master_data_wr), 64'(0));
    check_eq("mid_rst_done", 64'(sample_done), 64'(0));
    check_eq("mid_rst_start", 64'(master_start), 64'(0));
    $display("txn %0d: reset during WAIT after 2 transactions", txn_no);
    rr_model = 0;
    scramble_lanes();
    seq_pulses(0);
    run_txn(4'b1111, 4'b1100);

    // Randomized samples
    repeat (60) begin
      logic [N-1:0] en, val;
      en = N'($urandom);
      val = ($urandom_range(0, 2) == 0) ? 4'b1111 : N'($urandom);
      scramble_lanes();
      seq_random();
      run_txn(en, val);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Random bus pattern that is guaranteed to finish within the timer.
  task automatic seq_random_complete();
    int d, e, x;
    do begin
      seq_random();
      plan_txn(d, e, x);
    end while (e != 0);
  endtask

endmodule

// File: doc/wb_daq_channel_arbiter.md
Name: wb_daq_channel_arbiter

Overview:
Shares the single DAQ Wishbone bus master between NUM_CHANNELS acquisition channels using round-robin arbitration.
- Accepts one sample per grant over a valid/ready handshake.
- Presents the sample with that channel's vector-descriptor base address to the bus master as a start pulse.
- Tracks completion of the bus master's fixed 5-transaction sequence (3 pointer reads, data write, write-pointer write) by watching wb_cyc_o.
- Sits between the channel sample sources and the bus master inside the DAQ top level.

Parameters:
NUM_CHANNELS, 4, number of requesting channels (2..8)
dw, 32, data width
aw, 32, address width
TXN_PER_SAMPLE, 5, bus cycles the bus master performs per sample
TIMEOUT, 1024, max cycles allowed in WAIT before error (counter width clog2(TIMEOUT)+1)

Ports:
wb_clk  input  1  clock
wb_rst  input  1  synchronous active-high reset
control_reg  input  dw  [NUM_CHANNELS-1:0] channel enables; [31] error clear (level)
base_addresses  input  NUM_CHANNELS*aw  per-channel descriptor base, channel i at [i*aw +: aw]
ch_valid  input  NUM_CHANNELS  channel has a sample
ch_data  input  NUM_CHANNELS*dw  per-channel sample, channel i at [i*dw +: dw]
ch_ready  output  NUM_CHANNELS  one-hot accept; sample transfers when ch_valid[i] & ch_ready[i]
master_start  output  1  one-cycle start to the bus master
master_address  output  aw  descriptor base of the granted channel
master_data_wr  output  dw  captured sample
master_selection  output  4  constant 4'hF
master_write  output  1  constant 1
master_cyc  input  1  bus master wb_cyc_o
grant  output  NUM_CHANNELS  one-hot granted channel, held from ISSUE through DONE
busy  output  1  state != IDLE
sample_done  output  1  one-cycle pulse on successful completion
timeout_err  output  1  sticky error flag

Behaviour:
- Reset values: state IDLE; rr_ptr=0; grant=0; master_start=0; master_address=0; master_data_wr=0; busy=0; sample_done=0; timeout_err=0; cyc_q=0; counters 0. ch_ready=0 while not in IDLE.
- Eligible request: req[i] = ch_valid[i] & control_reg[i].
- Winner: first eligible index searching rr_ptr, rr_ptr+1, … mod NUM_CHANNELS.
- ch_ready is combinational: one-hot winner when state==IDLE and wb_rst==0, else 0.
- IDLE:
  - No eligible request: stay.
  - Otherwise handshake occurs this cycle: capture ch_data[winner] into master_data_wr and base_addresses[winner] into master_address, set grant, go ISSUE.
- ISSUE: master_start=1 for exactly this cycle (registered, so 1 cycle after handshake). Clear txn_cnt and timer. Go WAIT.
- WAIT:
  - cyc_q <= master_cyc every cycle. A falling edge (cyc_q & ~master_cyc) increments txn_cnt.
  - When the increment makes txn_cnt==TXN_PER_SAMPLE, go DONE.
  - Timer increments every WAIT cycle. If timer reaches TIMEOUT-1 without completion: set timeout_err, go ERROR.
  - Completion and timeout in the same cycle: completion wins.
- DONE: sample_done=1 for one cycle; rr_ptr <= (granted index + 1) mod NUM_CHANNELS; grant cleared; go IDLE.
- ERROR: grant held. Stay until master_cyc==0 for 2 consecutive cycles, then clear grant, advance rr_ptr as in DONE, go IDLE. The sample is dropped; sample_done is not pulsed.
- Stability: master_address and master_data_wr hold stable from capture until the next capture, because the bus master samples them combinationally in its idle/start cycle.
- Enable cleared mid-operation: the transaction in flight completes normally. A disabled channel is never granted afterward.
- timeout_err: cleared while control_reg[31]=1 unless being set the same cycle (set wins).
- Reset mid-operation: all state returns to reset values next edge; ch_ready forced 0 during reset; the partially done sample is lost.
- At most one sample in flight. Throughput bound = 1 sample per (3 + bus master duration) cycles.

Decomposition:
- Shared package/include wb_daq_arbiter_defs.vh:
  - state encodings IDLE=0, ISSUE=1, WAIT=2, DONE=3, ERROR=4 (3 bits)
  - TXN_PER_SAMPLE default
  - control_reg bit positions (CTRL_ERR_CLR_BIT=31)
- One sub-module: wb_daq_rr_picker. Combinational round-robin priority select: inputs req and rr_ptr, outputs one-hot winner, winner index, and any_req.

Test Plan:
- Single channel: enable=4'b0001, ch_valid[0]=1, data 0xDEADBEEF, base 0x1000 -> ch_ready[0] same cycle; master_start 1 cycle later with address 0x1000, data 0xDEADBEEF; after 5 cyc falling edges, sample_done pulses once; busy drops next cycle.
- Round-robin: all 4 channels valid continuously, all enabled -> grants in order 0,1,2,3,0 with exactly one start per grant; wrap from 3 to 0 confirmed.
- Disabled channel: enable=4'b1010, all valid -> only channels 1,3 granted, alternating; ch_ready[0], ch_ready[2] never asserted.
- Timeout: master_cyc held 0 after start, TIMEOUT=16 -> timeout_err set 16 cycles into WAIT, no sample_done, returns IDLE after 2 low-cyc cycles; control_reg[31]=1 clears it.
- Simultaneous completion/timeout: 5th falling edge on the final timer cycle -> DONE, timeout_err stays 0.
- Reset mid-WAIT after 2 transactions: wb_rst for 1 cycle -> all outputs at reset values, rr_ptr=0; next request from channel 2 is granted normally.
